// File: rtl/loop_seq_if.sv
// Bundle between the loop sequencer and its neighbours: start-loop handshake,
// ro_data read port, issue stream, and the create/iterate/finish outputs to the loop manager.
interface loop_seq_if #(
  parameter int BITS         = 18,
  parameter int LOOP_LOG_CNT = 3,
  parameter int ADDR_BITS    = 10,
  parameter int PC_BITS      = 10
) ();
  logic                    start_valid;
  logic                    start_ready;
  logic [ADDR_BITS-1:0]    start_desc_addr;
  logic [PC_BITS-1:0]      start_body_pc;
  logic                    start_independent;
  logic                    ro_rd_en;
  logic [ADDR_BITS-1:0]    ro_rd_addr;
  logic [BITS-1:0]         ro_rd_data;
  logic                    issue;
  logic [PC_BITS-1:0]      pc_in;
  logic                    loop_done;
  logic [BITS-1:0]         new_loop_iteration_count;
  logic                    new_loop_is_inner_independent_loop;
  logic [BITS-1:0]         addr0, daddr0, sx0, dsx0, sy0, dsy0;
  logic                    should_create_new_loop;
  logic                    did_start_next_loop_iteration;
  logic                    did_finish_loop;
  logic                    jump_valid;
  logic [PC_BITS-1:0]      jump_pc;
  logic [LOOP_LOG_CNT:0]   depth;
  logic                    desc_err;

  modport master (
    input  start_valid, start_desc_addr, start_body_pc, start_independent,
           ro_rd_data, issue, pc_in, loop_done,
    output start_ready, ro_rd_en, ro_rd_addr,
           new_loop_iteration_count, new_loop_is_inner_independent_loop,
           addr0, daddr0, sx0, dsx0, sy0, dsy0,
           should_create_new_loop, did_start_next_loop_iteration, did_finish_loop,
           jump_valid, jump_pc, depth, desc_err
  );

  modport slave (
    output start_valid, start_desc_addr, start_body_pc, start_independent,
           ro_rd_data, issue, pc_in, loop_done,
    input  start_ready, ro_rd_en, ro_rd_addr,
           new_loop_iteration_count, new_loop_is_inner_independent_loop,
           addr0, daddr0, sx0, dsx0, sy0, dsy0,
           should_create_new_loop, did_start_next_loop_iteration, did_finish_loop,
           jump_valid, jump_pc, depth, desc_err
  );
endinterface

// File: rtl/loop_sequencer.sv
// Fetches an 8-word loop descriptor, creates the loop in the loop manager and tracks loop-body
// PC bounds per nesting depth. Optional LOOP_SEQ_DESC_CHECK_EN rejects zero count / zero length.
module loop_sequencer #(
  parameter int BITS         = 18,
  parameter int LOOP_LOG_CNT = 3,
  parameter int ADDR_BITS    = 10,
  parameter int PC_BITS      = 10
) (
  input logic       clk,
  input logic       reset,
  loop_seq_if.master bus
);
  localparam int LOOP_CNT = 1 << LOOP_LOG_CNT;
  localparam logic [LOOP_LOG_CNT:0] DEPTH_FULL = (LOOP_LOG_CNT+1)'(LOOP_CNT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] CREATE = 2'd3;

  logic [1:0]               state;
  logic [2:0]               k, widx;
  logic                     wvld;
  logic [ADDR_BITS-1:0]     desc_addr;
  logic [PC_BITS-1:0]       body_pc;
  logic                     indep;
  logic [7:0][BITS-1:0]     word;
  logic [PC_BITS-1:0]       start_pc [LOOP_CNT];
  logic [PC_BITS-1:0]       end_pc   [LOOP_CNT];
  logic [LOOP_LOG_CNT:0]    depth;
  logic [LOOP_LOG_CNT-1:0]  top, slot;
  logic                     hit, pop, push, desc_ok, accept;
  logic                     unused_len_hi;

  assign unused_len_hi = ^word[7][BITS-1:PC_BITS];

  assign top  = LOOP_LOG_CNT'(depth - 1'b1);
  assign hit  = bus.issue && (depth != '0) && (bus.pc_in == end_pc[top]);
  assign pop  = hit && bus.loop_done;

`ifdef LOOP_SEQ_DESC_CHECK_EN
  assign desc_ok      = (word[6] != '0) && (word[7] != '0);
  assign bus.desc_err = (state == CREATE) && !desc_ok;
`else
  assign desc_ok      = 1'b1;
  assign bus.desc_err = 1'b0;
`endif

  assign push = (state == CREATE) && desc_ok;
  // pop-then-push: a coincident finish frees the top slot for the new entry
  assign slot = pop ? top : LOOP_LOG_CNT'(depth);

  assign accept          = bus.start_valid && bus.start_ready;
  assign bus.start_ready = (state == IDLE) && (depth < DEPTH_FULL);
  assign bus.ro_rd_en    = (state == FETCH);
  assign bus.ro_rd_addr  = (state == FETCH) ? desc_addr + ADDR_BITS'(k) : '0;

  assign bus.should_create_new_loop        = push;
  assign bus.did_finish_loop               = pop;
  assign bus.did_start_next_loop_iteration = hit && !bus.loop_done;
  assign bus.jump_valid                    = hit && !bus.loop_done;
  assign bus.jump_pc                       = (hit && !bus.loop_done) ? start_pc[top] : '0;
  assign bus.depth                         = depth;

  assign bus.addr0  = word[0];
  assign bus.daddr0 = word[1];
  assign bus.sx0    = word[2];
  assign bus.dsx0   = word[3];
  assign bus.sy0    = word[4];
  assign bus.dsy0   = word[5];
  assign bus.new_loop_iteration_count           = word[6];
  assign bus.new_loop_is_inner_independent_loop = indep;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      widx      <= '0;
      wvld      <= 1'b0;
      desc_addr <= '0;
      body_pc   <= '0;
      indep     <= 1'b0;
      word      <= '0;
      depth     <= '0;
      for (int i = 0; i < LOOP_CNT; i++) begin
        start_pc[i] <= '0;
        end_pc[i]   <= '0;
      end
    end else begin
      // read data lags the strobe by one cycle, so the slot index lags k
      wvld <= (state == FETCH);
      widx <= k;
      if (wvld) word[widx] <= bus.ro_rd_data;

      case (state)
        IDLE: if (accept) begin
          desc_addr <= bus.start_desc_addr;
          body_pc   <= bus.start_body_pc;
          indep     <= bus.start_independent;
          k         <= '0;
          state     <= FETCH;
        end
        FETCH: begin
          k <= k + 3'd1;
          if (k == 3'd7) state <= DRAIN;
        end
        DRAIN:   state <= CREATE;
        default: state <= IDLE;
      endcase

      if (push) begin
        start_pc[slot] <= body_pc;
        end_pc[slot]   <= body_pc + word[7][PC_BITS-1:0] - 1'b1;
      end

      if (push && !pop)      depth <= depth + 1'b1;
      else if (pop && !push) depth <= depth - 1'b1;
    end
  end
endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer: stimulus pushes expected events per output kind,
// a negedge monitor pops and compares whenever the DUT presents that output.
module tb_loop_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0, fails = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  loop_seq_if bus ();
  loop_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  logic [17:0] mem [0:1023];
  always @(posedge clk) if (bus.ro_rd_en) bus.ro_rd_data <= mem[bus.ro_rd_addr];

  typedef struct {
    int          cyc;
    logic [31:0] a, b, c, d;
  } ev_t;

  ev_t qrd[$], qcr[$], qerr[$], qnx[$], qfin[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    ev_t e;
    if (bus.ro_rd_en) begin
      if (qrd.size() == 0) chk("rd_unexpected", 32'(qrd.size()), 1);
      else begin
        e = qrd.pop_front();
        chk("rd_addr", 32'(bus.ro_rd_addr), e.a);
        chk("rd_cycle", cyc, e.cyc);
      end
    end
    if (bus.should_create_new_loop) begin
      if (qcr.size() == 0) chk("create_unexpected", 32'(qcr.size()), 1);
      else begin
        e = qcr.pop_front();
        chk("create_cycle", cyc, e.cyc);
        chk("create_count", 32'(bus.new_loop_iteration_count), e.a);
        chk("create_addr0", 32'(bus.addr0), e.b);
        chk("create_dsy0", 32'(bus.dsy0), e.c);
        chk("create_indep", 32'(bus.new_loop_is_inner_independent_loop), e.d);
      end
    end
    if (bus.desc_err) begin
      if (qerr.size() == 0) chk("err_unexpected", 32'(qerr.size()), 1);
      else begin
        e = qerr.pop_front();
        chk("err_cycle", cyc, e.cyc);
      end
    end
    if (bus.did_start_next_loop_iteration) begin
      if (qnx.size() == 0) chk("next_unexpected", 32'(qnx.size()), 1);
      else begin
        e = qnx.pop_front();
        chk("next_cycle", cyc, e.cyc);
        chk("next_jump_valid", 32'(bus.jump_valid), 1);
        chk("next_jump_pc", 32'(bus.jump_pc), e.a);
      end
    end
    if (bus.did_finish_loop) begin
      if (qfin.size() == 0) chk("finish_unexpected", 32'(qfin.size()), 1);
      else begin
        e = qfin.pop_front();
        chk("finish_cycle", cyc, e.cyc);
        chk("finish_no_jump", 32'(bus.jump_valid), 0);
      end
    end
    if (bus.jump_valid && !bus.did_start_next_loop_iteration)
      chk("jump_without_next", 32'(bus.jump_valid), 0);
  end

  // All tasks are entered and left at posedge+#1.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic start_loop(input logic [9:0] a, input logic [9:0] pc, input logic ind,
                            input bit exp_create, input logic [17:0] cnt,
                            input logic [17:0] a0, input logic [17:0] sy,
                            input bit wait_done, output int c0);
    ev_t e;
    int  n = 0;
    while (!bus.start_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n == 100) chk("start_ready_timeout", 32'(bus.start_ready), 1);
    bus.start_valid = 1'b1; bus.start_desc_addr = a;
    bus.start_body_pc = pc; bus.start_independent = ind;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      e = '{cyc: c0 + k, a: 32'(a) + 32'(k), b: 0, c: 0, d: 0};
      qrd.push_back(e);
    end
    e = '{cyc: c0 + 9, a: 32'(cnt), b: 32'(a0), c: 32'(sy), d: 32'(ind)};
    if (exp_create) qcr.push_back(e);
    else            qerr.push_back(e);
    if (wait_done) wait_cyc(c0 + 10);
  endtask

  task automatic issue_end(input logic [9:0] pc, input logic done, input int kind,
                           input logic [9:0] jpc);
    ev_t e;
    bus.issue = 1'b1; bus.pc_in = pc; bus.loop_done = done;
    e = '{cyc: cyc, a: 32'(jpc), b: 0, c: 0, d: 0};
    if (kind == 1) qnx.push_back(e);
    else if (kind == 2) qfin.push_back(e);
    @(posedge clk); #1;
    bus.issue = 1'b0; bus.loop_done = 1'b0;
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) begin
      mem[10'h40 + i] = 18'(i + 1);
      mem[10'h60 + i] = 18'(i + 11);
      mem[10'h80 + i] = 18'(i + 21);
      mem[10'hA0 + i] = 18'd7;
    end
    mem[10'h46] = 18'd5; mem[10'h47] = 18'd3;   // body 0x10..0x12
    mem[10'h66] = 18'd4; mem[10'h67] = 18'd4;   // body 0x20..0x23
    mem[10'h86] = 18'd9; mem[10'h87] = 18'd4;   // body 0x30..0x33
    mem[10'hA6] = 18'd0; mem[10'hA7] = 18'd2;   // zero iteration count

    reset = 1'b1;
    bus.start_valid = 1'b0; bus.start_desc_addr = '0; bus.start_body_pc = '0;
    bus.start_independent = 1'b0; bus.issue = 1'b0; bus.pc_in = '0; bus.loop_done = 1'b0;
    bus.ro_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", 32'(bus.start_ready), 1);
    chk("rst_rd_en", 32'(bus.ro_rd_en), 0);
    chk("rst_rd_addr", 32'(bus.ro_rd_addr), 0);
    chk("rst_depth", 32'(bus.depth), 0);
    chk("rst_jump_pc", 32'(bus.jump_pc), 0);
    chk("rst_create", 32'(bus.should_create_new_loop), 0);
    chk("rst_count", 32'(bus.new_loop_iteration_count), 0);
    chk("rst_addr0", 32'(bus.addr0), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // basic descriptor fetch and create
    start_loop(10'h40, 10'h10, 1'b0, 1'b1, 18'd5, 18'd1, 18'd6, 1'b1, c0);
    chk("depth_after_first", 32'(bus.depth), 1);

    // body end handling
    issue_end(10'h11, 1'b0, 0, 10'h0);
    issue_end(10'h12, 1'b0, 1, 10'h10);
    issue_end(10'h12, 1'b1, 2, 10'h0);
    chk("depth_after_finish", 32'(bus.depth), 0);
    issue_end(10'h12, 1'b0, 0, 10'h0);          // depth 0: ignored
    chk("depth_zero_ignore", 32'(bus.depth), 0);

    // fill the stack
    for (int i = 0; i < 7; i++)
      start_loop(10'h40, 10'h10, 1'b0, 1'b1, 18'd5, 18'd1, 18'd6, 1'b1, c0);
    start_loop(10'h60, 10'h20, 1'b1, 1'b1, 18'd4, 18'd11, 18'd16, 1'b1, c0);
    chk("depth_full", 32'(bus.depth), 8);
    chk("ready_when_full", 32'(bus.start_ready), 0);
    bus.start_valid = 1'b1; bus.start_desc_addr = 10'h40;
    repeat (5) begin @(posedge clk); #1; end
    bus.start_valid = 1'b0;
    issue_end(10'h23, 1'b1, 2, 10'h0);
    chk("depth_after_pop", 32'(bus.depth), 7);
    chk("ready_after_pop", 32'(bus.start_ready), 1);

    // finish on old top coincident with create
    start_loop(10'h80, 10'h30, 1'b0, 1'b1, 18'd9, 18'd21, 18'd26, 1'b0, c0);
    wait_cyc(c0 + 9);
    issue_end(10'h12, 1'b1, 2, 10'h0);
    chk("depth_coincident", 32'(bus.depth), 7);
    issue_end(10'h33, 1'b0, 1, 10'h30);
    issue_end(10'h33, 1'b1, 2, 10'h0);
    chk("depth_after_new_pop", 32'(bus.depth), 6);
    issue_end(10'h12, 1'b0, 1, 10'h10);

    // zero iteration count
`ifdef LOOP_SEQ_DESC_CHECK_EN
    start_loop(10'hA0, 10'h50, 1'b0, 1'b0, 18'd0, 18'd7, 18'd7, 1'b1, c0);
    chk("depth_after_reject", 32'(bus.depth), 6);
`else
    start_loop(10'hA0, 10'h50, 1'b0, 1'b1, 18'd0, 18'd7, 18'd7, 1'b1, c0);
    chk("depth_after_zero_create", 32'(bus.depth), 7);
`endif

    // reset in the middle of a fetch
    while (!bus.start_ready) begin @(posedge clk); #1; end
    bus.start_valid = 1'b1; bus.start_desc_addr = 10'h40; bus.start_body_pc = 10'h10;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 4; k++) qrd.push_back('{cyc: c0 + k, a: 32'h40 + 32'(k), b: 0, c: 0, d: 0});
    wait_cyc(c0 + 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_rd_en", 32'(bus.ro_rd_en), 0);
    chk("midrst_ready", 32'(bus.start_ready), 1);
    chk("midrst_depth", 32'(bus.depth), 0);
    repeat (20) begin @(posedge clk); #1; end

    chk("left_reads", 32'(qrd.size()), 0);
    chk("left_creates", 32'(qcr.size()), 0);
    chk("left_errs", 32'(qerr.size()), 0);
    chk("left_nexts", 32'(qnx.size()), 0);
    chk("left_finishes", 32'(qfin.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
